// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU/immediate
// select encodings and the FSM state type.
package cu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b101,
        ALU_PASSB = 3'b111
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // Which family of ALU operation the current state asks for.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_FUNCT,
        CLS_PASSB
    } alu_class_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the state's ALU class plus funct3/funct7[5] to an ALU operation and
// flags funct3 values the arithmetic datapath does not implement.
module alu_decoder
    import cu_pkg::*;
(
    input  alu_class_t i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_sub_en,
    output alu_ctrl_t  o_alu_ctrl,
    output logic       o_funct3_bad
);

    alu_ctrl_t w_funct_op;

    always_comb begin
        w_funct_op   = ALU_ADD;
        o_funct3_bad = 1'b0;
        case (i_funct3)
            3'b000:  w_funct_op = i_sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  w_funct_op = ALU_AND;
            3'b110:  w_funct_op = ALU_OR;
            3'b010:  w_funct_op = ALU_SLT;
            default: o_funct3_bad = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_class)
            CLS_SUB:   o_alu_ctrl = ALU_SUB;
            CLS_FUNCT: o_alu_ctrl = w_funct_op;
            CLS_PASSB: o_alu_ctrl = ALU_PASSB;
            default:   o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle Moore control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int RETIRE_WIDTH  = 32,
    parameter bit BNE_EN        = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDRESS_WIDTH-1:0] instr,
    input  logic                    EQ,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    IRWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    RegWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUsrcA,
    output logic [1:0]              ALUsrcB,
    output logic [2:0]              ImmSrc,
    output logic [2:0]              ALUctrl,
    output logic                    illegal,
    output logic [RETIRE_WIDTH-1:0] retired
);

    state_t                  r_state;
    state_t                  w_state_next;
    state_t                  w_decode_next;
    logic [RETIRE_WIDTH-1:0] r_retired;
    logic                    w_retire;
    alu_class_t              w_class;
    alu_ctrl_t               w_alu_ctrl;
    logic                    w_funct3_bad;
    logic                    w_branch_ok;
    logic [6:0]              w_opcode;
    logic [2:0]              w_funct3;
    logic                    w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_unused_instr = ^instr;
    assign w_branch_ok    = (w_funct3 == 3'b000) || ((w_funct3 == 3'b001) && BNE_EN);
    assign retired        = r_retired;

    always_comb begin
        w_class = CLS_ADD;
        case (r_state)
            S_EXEC_R, S_EXEC_I: w_class = CLS_FUNCT;
            S_BRANCH:           w_class = CLS_SUB;
            S_LUI:              w_class = CLS_PASSB;
            default:            w_class = CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_class      (w_class),
        .i_funct3     (w_funct3),
        .i_sub_en     (instr[30] && (r_state == S_EXEC_R)),
        .o_alu_ctrl   (w_alu_ctrl),
        .o_funct3_bad (w_funct3_bad)
    );

    // Anything that cannot execute falls straight back to FETCH from DECODE.
    always_comb begin
        w_decode_next = S_FETCH;
        case (w_opcode)
            OP_LOAD, OP_STORE: w_decode_next = S_MEMADR;
            OP_R:      w_decode_next = w_funct3_bad ? S_FETCH : S_EXEC_R;
            OP_I:      w_decode_next = w_funct3_bad ? S_FETCH : S_EXEC_I;
            OP_BRANCH: w_decode_next = w_branch_ok ? S_BRANCH : S_FETCH;
            OP_JAL:    w_decode_next = S_JAL;
            OP_LUI:    w_decode_next = S_LUI;
            default:   w_decode_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUsrcA      = 2'b00;
        ALUsrcB      = 2'b00;
        ImmSrc       = IMM_I;
        ALUctrl      = w_alu_ctrl;
        illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                PCWrite   = mem_ready;
                IRWrite   = mem_ready;
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUsrcA      = 2'b01;
                ALUsrcB      = 2'b01;
                ImmSrc       = IMM_B;
                illegal      = (w_decode_next == S_FETCH);
                w_state_next = w_decode_next;
            end
            S_MEMADR: begin
                ALUsrcA      = 2'b10;
                ALUsrcB      = 2'b01;
                ImmSrc       = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                w_state_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                RegWrite     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_retire = mem_ready;
                if (mem_ready) w_state_next = S_FETCH;
            end
            S_EXEC_R: begin
                ALUsrcA      = 2'b10;
                w_state_next = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUsrcA      = 2'b10;
                ALUsrcB      = 2'b01;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA      = 2'b10;
                PCWrite      = ((w_funct3 == 3'b000) && EQ) ||
                               ((w_funct3 == 3'b001) && !EQ && BNE_EN);
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                ALUsrcA      = 2'b01;
                ALUsrcB      = 2'b10;
                PCWrite      = 1'b1;
                w_state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUsrcB      = 2'b01;
                ImmSrc       = IMM_U;
                w_state_next = S_ALUWB;
            end
            default: w_state_next = S_FETCH;
        endcase
        // Outputs are forced low for the whole time reset is held.
        if (!rst_n) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 2'b00;
            ALUsrcA   = 2'b00;
            ALUsrcB   = 2'b00;
            ImmSrc    = 3'b000;
            ALUctrl   = 3'b000;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) r_retired <= r_retired + {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: a phase-level reference model predicts
// every cycle's control outputs; a negedge monitor compares them.
module tb_multicycle_cu;

    localparam int RW = 4;

    localparam int P_FETCH    = 0;
    localparam int P_DECODE   = 1;
    localparam int P_MEMADR   = 2;
    localparam int P_MEMREAD  = 3;
    localparam int P_MEMWB    = 4;
    localparam int P_MEMWRITE = 5;
    localparam int P_EXEC_R   = 6;
    localparam int P_EXEC_I   = 7;
    localparam int P_ALUWB    = 8;
    localparam int P_BRANCH   = 9;
    localparam int P_JAL      = 10;
    localparam int P_LUI      = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr = 32'h0;
    logic          EQ = 1'b0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, illegal;
    logic [1:0]    ResultSrc, ALUsrcA, ALUsrcB;
    logic [2:0]    ImmSrc, ALUctrl;
    logic [RW-1:0] retired;

    multicycle_cu #(
        .ADDRESS_WIDTH (32),
        .RETIRE_WIDTH  (RW),
        .BNE_EN        (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .EQ        (EQ),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ImmSrc    (ImmSrc),
        .ALUctrl   (ALUctrl),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // pcw ir adr mw rw | rs sa sb | imm alu | ill | retired
    logic [21:0] w_act;
    assign w_act = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
                    ALUsrcA, ALUsrcB, ImmSrc, ALUctrl, illegal, retired};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_ret = 0;
    bit          mon_en  = 1'b0;
    logic [21:0] exp_q[$];
    string       tag_q[$];

    function automatic bit is_legal(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011, 7'b0010011: return (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
            7'b1100011:             return (f3 == 3'd0) || (f3 == 3'd1);
            7'b0000011, 7'b0100011, 7'b1101111, 7'b0110111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] func_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b010:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [21:0] ref_out(input int ph, input logic [31:0] ins,
                                            input logic mr, input logic eq, input int ret);
        logic pcw, irw, adr, mw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu, f3;
        logic [RW-1:0] rr;
        pcw = 0; irw = 0; adr = 0; mw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; imm = 0; alu = 0;
        f3 = ins[14:12];
        rr = ret[RW-1:0];
        case (ph)
            P_FETCH:    begin pcw = mr; irw = mr; sb = 2'b10; rs = 2'b10; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b01; imm = 3'b010; ill = !is_legal(ins); end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; imm = (ins[6:0] == 7'b0100011) ? 3'b001 : 3'b000; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 2'b01; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXEC_R:   begin sa = 2'b10; alu = func_alu(f3, ins[30]); end
            P_EXEC_I:   begin sa = 2'b10; sb = 2'b01; alu = func_alu(f3, 1'b0); end
            P_ALUWB:    rw = 1;
            P_BRANCH:   begin sa = 2'b10; alu = 3'b001; pcw = (f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq); end
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            P_LUI:      begin sb = 2'b01; imm = 3'b100; alu = 3'b111; end
            default:    ;
        endcase
        return {pcw, irw, adr, mw, rw, rs, sa, sb, imm, alu, ill, rr};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  good;
        r = $urandom;
        case ($urandom_range(3, 0))
            0:       good = 3'b000;
            1:       good = 3'b111;
            2:       good = 3'b110;
            default: good = 3'b010;
        endcase
        case ($urandom_range(9, 0))
            0: begin r[6:0] = 7'b0110011; r[14:12] = good; end
            1: r[6:0] = 7'b0110011;
            2: begin r[6:0] = 7'b0010011; r[14:12] = good; end
            3: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            4: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            5: begin r[6:0] = 7'b1100011; r[14:12] = {2'b00, r[0]}; end
            6: r[6:0] = 7'b1101111;
            7: r[6:0] = 7'b0110111;
            8: r[1:0] = (r[1:0] == 2'b11) ? 2'b10 : r[1:0];
            default: r[6:0] = 7'b0010011;
        endcase
        return r;
    endfunction

    // Called at posedge+1: drive one cycle and queue its expected outputs.
    task automatic cycle(input int ph, input logic [31:0] ins, input logic mr,
                         input logic eq, input string tag);
        instr     = ins;
        mem_ready = mr;
        EQ        = eq;
        exp_q.push_back(ref_out(ph, ins, mr, eq, exp_ret));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait, input logic eq);
        int    n;
        string cls;
        n = 0;
        for (int k = 0; k < fwait; k++) begin
            cycle(P_FETCH, $urandom, 1'b0, 1'($urandom_range(1, 0)), "fetch_wait"); n++;
        end
        cycle(P_FETCH, $urandom, 1'b1, 1'($urandom_range(1, 0)), "fetch"); n++;
        cycle(P_DECODE, ins, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "decode"); n++;
        cls = "illegal";
        if (is_legal(ins)) begin
            case (ins[6:0])
                7'b0000011: begin
                    cls = "load";
                    cycle(P_MEMADR, ins, 1'($urandom_range(1, 0)), 1'b0, "memadr_ld"); n++;
                    for (int k = 0; k < mwait; k++) begin
                        cycle(P_MEMREAD, ins, 1'b0, 1'($urandom_range(1, 0)), "memread_wait"); n++;
                    end
                    cycle(P_MEMREAD, ins, 1'b1, 1'b0, "memread"); n++;
                    cycle(P_MEMWB, ins, 1'($urandom_range(1, 0)), 1'b0, "memwb"); n++;
                end
                7'b0100011: begin
                    cls = "store";
                    cycle(P_MEMADR, ins, 1'($urandom_range(1, 0)), 1'b0, "memadr_st"); n++;
                    for (int k = 0; k < mwait; k++) begin
                        cycle(P_MEMWRITE, ins, 1'b0, 1'($urandom_range(1, 0)), "memwrite_wait"); n++;
                    end
                    cycle(P_MEMWRITE, ins, 1'b1, 1'b0, "memwrite"); n++;
                end
                7'b0110011: begin
                    cls = "rtype";
                    cycle(P_EXEC_R, ins, 1'($urandom_range(1, 0)), 1'b0, "exec_r"); n++;
                    cycle(P_ALUWB, ins, 1'($urandom_range(1, 0)), 1'b0, "aluwb"); n++;
                end
                7'b0010011: begin
                    cls = "itype";
                    cycle(P_EXEC_I, ins, 1'($urandom_range(1, 0)), 1'b0, "exec_i"); n++;
                    cycle(P_ALUWB, ins, 1'($urandom_range(1, 0)), 1'b0, "aluwb"); n++;
                end
                7'b1100011: begin
                    cls = "branch";
                    cycle(P_BRANCH, ins, 1'($urandom_range(1, 0)), eq, "branch"); n++;
                end
                7'b1101111: begin
                    cls = "jal";
                    cycle(P_JAL, ins, 1'($urandom_range(1, 0)), 1'b0, "jal"); n++;
                    cycle(P_ALUWB, ins, 1'($urandom_range(1, 0)), 1'b0, "aluwb"); n++;
                end
                default: begin
                    cls = "lui";
                    cycle(P_LUI, ins, 1'($urandom_range(1, 0)), 1'b0, "lui"); n++;
                    cycle(P_ALUWB, ins, 1'($urandom_range(1, 0)), 1'b0, "aluwb"); n++;
                end
            endcase
            exp_ret = (exp_ret + 1) % (1 << RW);
        end
        $display("[TB] instr %08h %s cycles %0d retired_exp %0d", ins, cls, n, exp_ret);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h required %08h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] e;
        string       t;
        if (mon_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got output %06h required none queued", w_act);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (w_act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %06h required %06h (pcw,ir,adr,mw,rw,rs2,sa2,sb2,imm3,alu3,ill,ret4) t=%0t",
                             t, w_act, e, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        EQ        = 1'b1;
        instr     = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs_zero", 32'(w_act), 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0);  // add x3,x1,x2
        run_instr(32'h0000A183, 0, 2, 1'b0);  // lw with two memory wait states
        run_instr(32'h00208063, 0, 0, 1'b1);  // beq, taken
        run_instr(32'h00209063, 0, 0, 1'b1);  // bne, not taken
        run_instr(32'h0000007F, 0, 0, 1'b0);  // unsupported opcode
        run_instr(32'h40208033, 1, 0, 1'b0);  // sub after a fetch stall
        run_instr(32'h0020C1B3, 0, 0, 1'b0);  // R-type funct3 100: illegal

        for (int i = 0; i < 150; i++) begin
            run_instr(rand_instr(),
                      ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0,
                      ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0,
                      1'($urandom_range(1, 0)));
        end

        // Store stalled in MEMWRITE, then reset asserted mid-cycle.
        cycle(P_FETCH, $urandom, 1'b1, 1'b0, "fetch");
        cycle(P_DECODE, 32'h0020A023, 1'b0, 1'b0, "decode");
        cycle(P_MEMADR, 32'h0020A023, 1'b0, 1'b0, "memadr_st");
        cycle(P_MEMWRITE, 32'h0020A023, 1'b0, 1'b0, "memwrite_wait");
        mon_en = 1'b0;
        #1;
        check("memwrite_before_reset", 32'(MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        check("memwrite_async_drop", 32'(MemWrite), 32'h0);
        check("reset_retired_zero", 32'(retired), 32'h0);
        check("reset_all_zero", 32'(w_act), 32'h0);
        exp_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_instr(32'h00108093, ($urandom_range(3, 0) == 0) ? 1 : 0, 0, 1'b0);  // addi x1,x1,1
        end
        check("retired_wrap", 32'(retired), 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_instr(rand_instr(), 0, $urandom_range(1, 0), 1'($urandom_range(1, 0)));
        end

        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle control unit for the RV32I-subset single-issue core; successor to the single-cycle combinational control unit.
- Sequences every instruction through a Moore FSM: fetch, decode, execute, memory, writeback.
- Drives datapath selects and enables from latched instruction fields, the ALU EQ flag and a memory-ready handshake.
- Keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- ADDRESS_WIDTH, 32, instruction word width (opcode in [6:0], funct3 in [14:12], funct7[5] in [30]).
- RETIRE_WIDTH, 32, width of the retired-instruction counter.
- BNE_EN, 1, 1 = BNE (funct3 001) decoded as a branch; 0 = BNE treated as illegal.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  ADDRESS_WIDTH  instruction register contents, stable from DECODE onward.
- EQ  in  1  ALU equality flag (rs1 == rs2), valid in BRANCH.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  load PC.
- IRWrite  out  1  load instruction register.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- ALUsrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- ALUsrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 pass-B.
- illegal  out  1  pulses 1 cycle in DECODE on an unsupported opcode or funct3.
- retired  out  RETIRE_WIDTH  count of completed instructions.

Behaviour:
- Reset (async, rst_n low): state = FETCH, retired = 0, all outputs 0. Leaving reset mid-instruction abandons it.
- Outputs are Moore, decoded from state only. ALUctrl and ImmSrc additionally depend on latched instr fields.

State transitions:
- FETCH: AdrSrc = 0, IRWrite = 1, ALUsrcA = 00, ALUsrcB = 10, ALUctrl = add, ResultSrc = 10.
  - PCWrite = mem_ready, IRWrite is qualified by mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready = 1.
- DECODE: ALUsrcA = 01, ALUsrcB = 01, ImmSrc = B, ALUctrl = add (branch target precomputed). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - otherwise -> FETCH with illegal = 1; retired does not increment.
- MEMADR: ALUsrcA = 10, ALUsrcB = 01, ImmSrc = I for load or S for store, ALUctrl = add. Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: AdrSrc = 1. Stays while !mem_ready, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1. Next FETCH.
- MEMWRITE: AdrSrc = 1, MemWrite = 1 held until mem_ready. Next FETCH.
- EXEC_R: ALUsrcA = 10, ALUsrcB = 00. ALUctrl from funct3:
  - 000 -> add, or sub when funct7[5] = 1
  - 111 -> and
  - 110 -> or
  - 010 -> slt
  - other funct3 -> illegal in DECODE.
  Next ALUWB.
- EXEC_I: as EXEC_R but ALUsrcB = 01, ImmSrc = I, funct7 ignored. Next ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Next FETCH.
- BRANCH: ALUsrcA = 10, ALUsrcB = 00, ALUctrl = sub, ResultSrc = 00.
  - PCWrite = (funct3 = 000 & EQ) | (funct3 = 001 & !EQ & BNE_EN).
  - Next FETCH.
- JAL: ALUsrcA = 01, ALUsrcB = 10, ALUctrl = add, ResultSrc = 00, PCWrite = 1. Next ALUWB (rd = PC + 4).
- LUI: ALUsrcB = 01, ImmSrc = U, ALUctrl = pass-B. Next ALUWB.

Retired counter and latency:
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH. It wraps modulo 2^RETIRE_WIDTH.
- Latency with zero wait states: branch 3, R/I/LUI 4, store 4, JAL 4, load 5 cycles.
- Each mem_ready = 0 cycle adds one cycle in the waiting state; no outputs change while waiting.
- MemWrite and RegWrite are never both high.

Decomposition:
- Shared package cu_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI)
  - ALUctrl and ImmSrc enums
  - state_t enum.
- Sub-module alu_decoder: combinational mapping of (state class, funct3, funct7[5]) to ALUctrl plus an illegal-funct3 flag. The FSM lives in multicycle_cu.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready = 1 -> states FETCH, DECODE, EXEC_R, ALUWB. ALUctrl = 000. RegWrite high in cycle 4 only. retired 0 -> 1.
- lw (0x0000A183) with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total. ResultSrc = 01 and RegWrite = 1 in MEMWB.
- beq with EQ = 1, then bne with EQ = 1 (BNE_EN = 1) -> PCWrite = 1 in BRANCH for the beq only. Each takes 3 cycles.
- Opcode 0x7F -> illegal pulses 1 cycle, returns to FETCH, retired unchanged.
- rst_n asserted during MEMWRITE -> MemWrite drops to 0 immediately (async). After release, FSM is in FETCH with retired = 0.
- RETIRE_WIDTH = 4, 16 consecutive addi -> retired wraps to 0.
